// File: rtl/dffre_stim_gen.sv
// Stimulus sequencer for a resettable/enabled D flip-flop under test.
// It runs a fixed six-entry directed table, then NUM_RANDOM steps taken
// from a 16-bit Fibonacci LFSR, and then parks in DONE. It also emits a
// one-cycle compare strobe in the last cycle of every step.
module dffre_stim_gen #(
    parameter int          STEP_CYCLES = 2,
    parameter int          NUM_RANDOM  = 1000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic        i_Hold,
    output logic        o_Reset,
    output logic        o_Enable,
    output logic        o_D,
    output logic        o_Compare,
    output logic [15:0] o_StepCount,
    output logic        o_Done
);

    // A seed of zero would lock the LFSR up, so it is swapped for the default.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [7:0]  LAST_CYC  = 8'(STEP_CYCLES - 1);
    localparam logic [15:0] LAST_DIR  = 16'd5;
    localparam logic [15:0] LAST_STEP = 16'(6 + NUM_RANDOM - 1);

    typedef enum logic [1:0] {IDLE, DIRECTED, RANDOM, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [15:0] cnt_q, cnt_d;
    logic        r_q, r_d, e_q, e_d, d_q, d_d, done_q, done_d;
    logic        step_end;

    // Directed vectors, packed as {R, E, D}.
    function automatic logic [2:0] dir_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    dir_vec = 3'b100;
            3'd1:    dir_vec = 3'b001;
            3'd2:    dir_vec = 3'b011;
            3'd3:    dir_vec = 3'b010;
            3'd4:    dir_vec = 3'b001;
            default: dir_vec = 3'b011;
        endcase
    endfunction

    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign step_end = (cyc_q == LAST_CYC);

    // Next-state logic. A held cycle leaves every register untouched, so the
    // cycle position inside the step resumes where it stopped.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        e_d     = e_q;
        d_d     = d_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                // A start is accepted even while i_Hold is high. The block
                // then waits in step 0 until the hold is released.
                if (i_Start) begin
                    state_d           = DIRECTED;
                    cyc_d             = 8'd0;
                    cnt_d             = 16'd0;
                    lfsr_d            = SEED_EFF;
                    {r_d, e_d, d_d}   = dir_vec(3'd0);
                    done_d            = 1'b0;
                end
            end
            DIRECTED: begin
                if (!i_Hold) begin
                    if (step_end) begin
                        cyc_d = 8'd0;
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == LAST_DIR) begin
                            state_d = RANDOM;
                            lfsr_d  = lfsr_adv;
                            r_d     = 1'b0;
                            e_d     = lfsr_adv[1];
                            d_d     = lfsr_adv[0];
                        end else begin
                            {r_d, e_d, d_d} = dir_vec(cnt_q[2:0] + 3'd1);
                        end
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
            end
            RANDOM: begin
                if (!i_Hold) begin
                    if (step_end) begin
                        cyc_d = 8'd0;
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == LAST_STEP) begin
                            // o_D keeps its last value in DONE.
                            state_d = DONE;
                            r_d     = 1'b0;
                            e_d     = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            lfsr_d = lfsr_adv;
                            r_d    = 1'b0;
                            e_d    = lfsr_adv[1];
                            d_d    = lfsr_adv[0];
                        end
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset aborts immediately to the idle values.
    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            cyc_q   <= 8'd0;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= 16'd0;
            r_q     <= 1'b1;
            e_q     <= 1'b0;
            d_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            e_q     <= e_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    // The strobe is combinational so that i_Hold suppresses it in the same cycle.
    assign o_Compare   = ((state_q == DIRECTED) || (state_q == RANDOM)) && !i_Hold && step_end;
    assign o_Reset     = r_q;
    assign o_Enable    = e_q;
    assign o_D         = d_q;
    assign o_StepCount = cnt_q;
    assign o_Done      = done_q;

endmodule

// File: tb/tb_dffre_stim_gen.sv
// Bench for dffre_stim_gen. It runs three instances that share the same
// inputs: the base configuration, a configuration with SEED=0, and a
// configuration with STEP_CYCLES=1. A scoreboard per instance checks each
// compare strobe against a reference vector stream.
module tb_dffre_stim_gen;

    logic        clk = 1'b0;
    logic        i_Reset, i_Start, i_Hold;
    logic [2:0]  r_o, e_o, d_o, c_o, dn_o;
    logic [15:0] sc_o [3];

    int          total = 0;
    int          bad   = 0;
    int          cmp_cnt [3];
    logic [18:0] sb [3][$];
    logic        last_d;

    localparam logic [2:0] DIR_TBL [6] = '{3'b100, 3'b001, 3'b011, 3'b010, 3'b001, 3'b011};

    always #5 clk = ~clk;

    dffre_stim_gen #(.STEP_CYCLES(2), .NUM_RANDOM(4), .SEED(16'hACE1)) u_base (
        .clk(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Hold(i_Hold),
        .o_Reset(r_o[0]), .o_Enable(e_o[0]), .o_D(d_o[0]), .o_Compare(c_o[0]),
        .o_StepCount(sc_o[0]), .o_Done(dn_o[0]));

    dffre_stim_gen #(.STEP_CYCLES(2), .NUM_RANDOM(4), .SEED(16'h0000)) u_zero (
        .clk(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Hold(i_Hold),
        .o_Reset(r_o[1]), .o_Enable(e_o[1]), .o_D(d_o[1]), .o_Compare(c_o[1]),
        .o_StepCount(sc_o[1]), .o_Done(dn_o[1]));

    dffre_stim_gen #(.STEP_CYCLES(1), .NUM_RANDOM(4), .SEED(16'hACE1)) u_fast (
        .clk(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Hold(i_Hold),
        .o_Reset(r_o[2]), .o_Enable(e_o[2]), .o_D(d_o[2]), .o_Compare(c_o[2]),
        .o_StepCount(sc_o[2]), .o_Done(dn_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic flush();
        for (int i = 0; i < 3; i++) sb[i].delete();
    endtask

    // Builds the expected run: {R,E,D, step count at the compare}.
    task automatic load_expect();
        logic [15:0] s;
        logic [18:0] v;
        s = 16'hACE1;
        flush();
        for (int i = 0; i < 3; i++) cmp_cnt[i] = 0;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 3; i++) sb[i].push_back({DIR_TBL[k], 16'(k)});
        for (int k = 0; k < 4; k++) begin
            s = lfsr_step(s);
            v = {1'b0, s[1], s[0], 16'(6 + k)};
            for (int i = 0; i < 3; i++) sb[i].push_back(v);
            last_d = s[0];
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Checks happen on the
    // falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        cyc();
        i_Start = 1'b1;
        cyc();
        i_Start = 1'b0;
    endtask

    task automatic wait_done_and_check();
        int n;
        n = 0;
        while (dn_o !== 3'b111 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", 32'(n < 200), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("final_cnt%0d", i), 32'(sc_o[i]), 32'd10);
            chk($sformatf("cmp_total%0d", i), 32'(cmp_cnt[i]), 32'd10);
            chk($sformatf("sb_drained%0d", i), 32'(sb[i].size()), 32'd0);
        end
        chk("done_outs", {r_o[0], e_o[0], c_o[0], d_o[0]}, {3'b000, last_d});
    endtask

    // Scoreboard monitor: every strobe must match the next expected vector.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (c_o[i] === 1'b1) begin
                cmp_cnt[i]++;
                chk($sformatf("sb_avail%0d", i), 32'(sb[i].size() > 0), 32'd1);
                if (sb[i].size() > 0)
                    chk($sformatf("sb_vec%0d", i), {r_o[i], e_o[i], d_o[i], sc_o[i]}, 32'(sb[i].pop_front()));
            end
        end
    end

    initial begin
        int n;
        i_Reset = 1'b1;
        i_Start = 1'b0;
        i_Hold  = 1'b0;

        // Reset, then idle
        repeat (3) @(negedge clk);
        chk("rst_outs", {r_o[0], e_o[0], d_o[0], c_o[0], dn_o[0], sc_o[0]}, {5'b10000, 16'd0});
        cyc();
        i_Reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_outs", {r_o[0], e_o[0], d_o[0], c_o[0], dn_o[0], sc_o[0]}, {5'b10000, 16'd0});
            if (k < 9) cyc();
        end

        // Run 1: directed timing, with the fast instance strobing every cycle
        load_expect();
        start_pulse();
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) cyc();
            @(negedge clk);
            chk("dir_cmp", 32'(c_o[0]), 32'(k % 2 == 0));
            chk("dir_vec", {r_o[0], e_o[0], d_o[0]}, DIR_TBL[(k - 1) / 2]);
            chk("dir_cnt", 32'(sc_o[0]), 32'((k - 1) / 2));
            if (k <= 10) chk("fast_cmp", 32'(c_o[2]), 32'd1);
        end
        wait_done_and_check();

        // Run 2: restart from DONE, holding from the cycle before step 2's compare
        load_expect();
        start_pulse();
        repeat (4) cyc();
        i_Hold = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("hold_frozen", {c_o[0], r_o[0], e_o[0], d_o[0], sc_o[0]}, {4'b0011, 16'd2});
            if (j < 4) cyc();
        end
        cyc();
        i_Hold = 1'b0;
        @(negedge clk);
        chk("rel_cyc0", 32'(c_o[0]), 32'd0);
        cyc();
        @(negedge clk);
        chk("rel_cmp", 32'(c_o[0]), 32'd1);
        wait_done_and_check();

        // Run 3: reset during random step 3, then rerun
        load_expect();
        start_pulse();
        n = 0;
        while (sc_o[0] !== 16'd8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rand3", 32'(n < 100), 32'd1);
        cyc();
        i_Reset = 1'b1;
        flush();
        @(negedge clk);
        chk("midrst_outs", {r_o[0], e_o[0], c_o[0], dn_o[0], sc_o[0]}, {4'b1000, 16'd0});
        cyc();
        i_Reset = 1'b0;
        load_expect();
        start_pulse();
        wait_done_and_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
